id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register directly upstream of the ALU. It captures decoded operands and control, then drives the ALU's A, B and ALUOp inputs.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Supports a valid/ready handshake with decode (upstream) and memory stage (downstream), plus a synchronous flush for branches and jumps.

---
 rtl/id_ex_operand_stage.sv | 167 ++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register in front of the ALU. Holds one decoded instruction behind a
// valid/ready handshake and forwards EX/MEM and MEM/WB results onto the stored operands.
module id_ex_operand_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [3:0]        in_alu_op,
    input  logic              in_src_a_pc,
    input  logic              in_src_b_imm,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic              in_reg_write,

    input  logic              flush,

    input  logic              fwd_em_we,
    input  logic [REG_AW-1:0] fwd_em_rd,
    input  logic [XLEN-1:0]   fwd_em_data,
    input  logic              fwd_mw_we,
    input  logic [REG_AW-1:0] fwd_mw_rd,
    input  logic [XLEN-1:0]   fwd_mw_data,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_op,
    output logic [XLEN-1:0]   out_rs2_fwd,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_reg_write
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;

    logic [XLEN-1:0]   pc_q;
    logic [REG_AW-1:0] rs1_addr_q;
    logic [REG_AW-1:0] rs2_addr_q;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q;
    logic [3:0]        alu_op_q;
    logic              src_a_pc_q;
    logic              src_b_imm_q;
    logic [REG_AW-1:0] rd_addr_q;
    logic              reg_write_q;

    logic              load;
    logic              stall;
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;

    // Handshake qualifiers; flush overrides both load and stall refresh
    always_comb begin
        out_valid = (state_q == FULL);
        in_ready  = !out_valid || out_ready;
        load      = in_valid && in_ready && !flush;
        stall     = out_valid && !out_ready && !flush;
    end

    // Valid-bit next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (load) begin
            state_d = FULL;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-operand forwarding: EX/MEM beats MEM/WB, x0 is never bypassed
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (rs1_addr_q != '0) begin
            if (fwd_em_we && (fwd_em_rd == rs1_addr_q)) begin
                fwd_rs1 = fwd_em_data;
            end else if (fwd_mw_we && (fwd_mw_rd == rs1_addr_q)) begin
                fwd_rs1 = fwd_mw_data;
            end
        end
        fwd_rs2 = rs2_data_q;
        if (rs2_addr_q != '0) begin
            if (fwd_em_we && (fwd_em_rd == rs2_addr_q)) begin
                fwd_rs2 = fwd_em_data;
            end else if (fwd_mw_we && (fwd_mw_rd == rs2_addr_q)) begin
                fwd_rs2 = fwd_mw_data;
            end
        end
    end

    // Operand values: capture on load, re-capture forwarded values while stalled
    always_comb begin
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        if (load) begin
            rs1_data_d = in_rs1_data;
            rs2_data_d = in_rs2_data;
        end else if (stall) begin
            rs1_data_d = fwd_rs1;
            rs2_data_d = fwd_rs2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_op_q    <= '0;
            src_a_pc_q  <= 1'b0;
            src_b_imm_q <= 1'b0;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
        end else begin
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            if (load) begin
                pc_q        <= in_pc;
                rs1_addr_q  <= in_rs1_addr;
                rs2_addr_q  <= in_rs2_addr;
                imm_q       <= in_imm;
                alu_op_q    <= in_alu_op;
                src_a_pc_q  <= in_src_a_pc;
                src_b_imm_q <= in_src_b_imm;
                rd_addr_q   <= in_rd_addr;
                reg_write_q <= in_reg_write;
            end
        end
    end

    always_comb begin
        alu_a         = src_a_pc_q ? pc_q : fwd_rs1;
        alu_b         = src_b_imm_q ? imm_q : fwd_rs2;
        alu_op        = alu_op_q;
        out_rs2_fwd   = fwd_rs2;
        out_rd_addr   = rd_addr_q;
        out_reg_write = reg_write_q && out_valid;
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: stimulus queues expected ALU-side results,
// a negedge monitor pops and compares on each downstream transfer.
module tb_id_ex_operand_stage;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [REG_AW-1:0] in_rs1_addr;
    logic [REG_AW-1:0] in_rs2_addr;
    logic [XLEN-1:0]   in_rs1_data;
    logic [XLEN-1:0]   in_rs2_data;
    logic [XLEN-1:0]   in_imm;
    logic [3:0]        in_alu_op;
    logic              in_src_a_pc;
    logic              in_src_b_imm;
    logic [REG_AW-1:0] in_rd_addr;
    logic              in_reg_write;
    logic              flush;
    logic              fwd_em_we;
    logic [REG_AW-1:0] fwd_em_rd;
    logic [XLEN-1:0]   fwd_em_data;
    logic              fwd_mw_we;
    logic [REG_AW-1:0] fwd_mw_rd;
    logic [XLEN-1:0]   fwd_mw_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic [3:0]        alu_op;
    logic [XLEN-1:0]   out_rs2_fwd;
    logic [REG_AW-1:0] out_rd_addr;
    logic              out_reg_write;

    id_ex_operand_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_rs1_addr  (in_rs1_addr),
        .in_rs2_addr  (in_rs2_addr),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .in_imm       (in_imm),
        .in_alu_op    (in_alu_op),
        .in_src_a_pc  (in_src_a_pc),
        .in_src_b_imm (in_src_b_imm),
        .in_rd_addr   (in_rd_addr),
        .in_reg_write (in_reg_write),
        .flush        (flush),
        .fwd_em_we    (fwd_em_we),
        .fwd_em_rd    (fwd_em_rd),
        .fwd_em_data  (fwd_em_data),
        .fwd_mw_we    (fwd_mw_we),
        .fwd_mw_rd    (fwd_mw_rd),
        .fwd_mw_data  (fwd_mw_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .out_rs2_fwd  (out_rs2_fwd),
        .out_rd_addr  (out_rd_addr),
        .out_reg_write(out_reg_write)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] rs2f;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } dchk_t;

    exp_t  sb_q[$];
    dchk_t dq[$];
    int    checks = 0;
    int    errors = 0;
    bit    done   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dcheck(input string nm, input logic [31:0] act, input logic [31:0] exp);
        dchk_t d;
        d.name = nm;
        d.act  = act;
        d.exp  = exp;
        dq.push_back(d);
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                            input logic [31:0] rs2f, input logic [4:0] rd, input logic rw);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.rs2f = rs2f; e.rd = rd; e.rw = rw;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rs1a, input logic [31:0] rs1d,
                         input logic [4:0] rs2a, input logic [31:0] rs2d, input logic [31:0] imm,
                         input logic [3:0] op, input logic sapc, input logic sbimm,
                         input logic [4:0] rd, input logic rw);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_rs1_addr  = rs1a;
        in_rs1_data  = rs1d;
        in_rs2_addr  = rs2a;
        in_rs2_data  = rs2d;
        in_imm       = imm;
        in_alu_op    = op;
        in_src_a_pc  = sapc;
        in_src_b_imm = sbimm;
        in_rd_addr   = rd;
        in_reg_write = rw;
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: compare every downstream transfer against the scoreboard head
    initial begin
        exp_t  e;
        dchk_t d;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready && !flush) begin
                if (sb_q.size() == 0) begin
                    cmp("unexpected_transfer", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    cmp("alu_a", alu_a, e.a);
                    cmp("alu_b", alu_b, e.b);
                    cmp("alu_op", 32'(alu_op), 32'(e.op));
                    cmp("out_rs2_fwd", out_rs2_fwd, e.rs2f);
                    cmp("out_rd_addr", 32'(out_rd_addr), 32'(e.rd));
                    cmp("out_reg_write", 32'(out_reg_write), 32'(e.rw));
                end
            end
            while (dq.size() > 0) begin
                d = dq.pop_front();
                cmp(d.name, d.act, d.exp);
            end
            if (done) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_rs1_addr = '0; in_rs2_addr = '0;
        in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_alu_op = '0; in_src_a_pc = 1'b0;
        in_src_b_imm = 1'b0; in_rd_addr = '0; in_reg_write = 1'b0; flush = 1'b0;
        fwd_em_we = 1'b0; fwd_em_rd = '0; fwd_em_data = '0;
        fwd_mw_we = 1'b0; fwd_mw_rd = '0; fwd_mw_data = '0; out_ready = 1'b0;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        dcheck("rst_out_valid", 32'(out_valid), 32'd0);
        dcheck("rst_alu_a", alu_a, 32'd0);
        dcheck("rst_alu_b", alu_b, 32'd0);
        dcheck("rst_alu_op", 32'(alu_op), 32'd0);
        dcheck("rst_rd_addr", 32'(out_rd_addr), 32'd0);
        dcheck("rst_reg_write", 32'(out_reg_write), 32'd0);
        dcheck("rst_rs2_fwd", out_rs2_fwd, 32'd0);
        dcheck("rst_in_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        // Async reset while holding a SUB
        drive(32'h40, 5'd1, 32'h10, 5'd2, 32'h20, 32'h0, 4'b1000, 1'b0, 1'b0, 5'd3, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        dcheck("held_valid", 32'(out_valid), 32'd1);
        dcheck("held_alu_op", 32'(alu_op), 32'd8);
        #2 rst_n = 1'b0;
        #1;
        dcheck("async_rst_valid", 32'(out_valid), 32'd0);
        dcheck("async_rst_alu_op", 32'(alu_op), 32'd0);
        dcheck("async_rst_reg_write", 32'(out_reg_write), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // ADD x1(5) + x2(7)
        out_ready = 1'b1;
        drive(32'h80, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 4'b0000, 1'b0, 1'b0, 5'd4, 1'b1);
        push_exp(32'd5, 32'd7, 4'b0000, 32'd7, 5'd4, 1'b1);
        step();
        in_valid = 1'b0;
        step();

        // Forward priority on rs1=x3 while stalled
        out_ready = 1'b0;
        drive(32'h84, 5'd3, 32'd1, 5'd0, 32'd9, 32'h0, 4'b0000, 1'b0, 1'b0, 5'd5, 1'b1);
        step();
        in_valid = 1'b0;
        fwd_em_we = 1'b1; fwd_em_rd = 5'd3; fwd_em_data = 32'hAA;
        fwd_mw_we = 1'b1; fwd_mw_rd = 5'd3; fwd_mw_data = 32'hBB;
        @(negedge clk);
        dcheck("fwd_em_wins", alu_a, 32'hAA);
        step();
        fwd_em_we = 1'b0;
        @(negedge clk);
        dcheck("fwd_mw_only", alu_a, 32'hBB);
        step();
        fwd_mw_we = 1'b0;
        @(negedge clk);
        dcheck("fwd_refreshed_rs1", alu_a, 32'hBB);
        dcheck("rs2_x0_stored", alu_b, 32'd9);
        step();
        push_exp(32'hBB, 32'd9, 4'b0000, 32'd9, 5'd5, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // x0 never forwards
        drive(32'h88, 5'd0, 32'h55, 5'd0, 32'h66, 32'h0, 4'b0000, 1'b0, 1'b0, 5'd0, 1'b0);
        step();
        in_valid = 1'b0;
        fwd_em_we = 1'b1; fwd_em_rd = 5'd0; fwd_em_data = 32'hAA;
        fwd_mw_we = 1'b1; fwd_mw_rd = 5'd0; fwd_mw_data = 32'hBB;
        @(negedge clk);
        dcheck("x0_no_fwd_a", alu_a, 32'h55);
        dcheck("x0_no_fwd_rs2", out_rs2_fwd, 32'h66);
        step();
        push_exp(32'h55, 32'h66, 4'b0000, 32'h66, 5'd0, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        fwd_em_we = 1'b0;
        fwd_mw_we = 1'b0;

        // Stall refresh keeps a retired producer's value
        drive(32'h8C, 5'd1, 32'd3, 5'd2, 32'd0, 32'h0, 4'b1000, 1'b0, 1'b0, 5'd6, 1'b1);
        step();
        in_valid = 1'b0;
        fwd_mw_we = 1'b1; fwd_mw_rd = 5'd2; fwd_mw_data = 32'h1234;
        step();
        fwd_mw_we = 1'b0;
        @(negedge clk);
        dcheck("refresh_alu_b", alu_b, 32'h1234);
        dcheck("refresh_rs2_fwd", out_rs2_fwd, 32'h1234);
        dcheck("refresh_valid", 32'(out_valid), 32'd1);
        step();
        push_exp(32'd3, 32'h1234, 4'b1000, 32'h1234, 5'd6, 1'b1);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        dcheck("consumed_valid", 32'(out_valid), 32'd0);
        dcheck("consumed_rw_gated", 32'(out_reg_write), 32'd0);
        step();

        // Back-to-back throughput
        for (int i = 0; i < 4; i++) begin
            drive(32'(32'h200 + 4 * i), 5'(8 + i), 32'(100 + i), 5'(12 + i), 32'(200 + i),
                  32'(16 * i), 4'(i), 1'b0, ((i % 2) == 1), 5'(16 + i), 1'b1);
            push_exp(32'(100 + i), ((i % 2) == 1) ? 32'(16 * i) : 32'(200 + i), 4'(i),
                     32'(200 + i), 5'(16 + i), 1'b1);
            @(negedge clk);
            dcheck("b2b_in_ready", 32'(in_ready), 32'd1);
            if (i > 0) dcheck("b2b_out_valid", 32'(out_valid), 32'd1);
            step();
        end
        in_valid = 1'b0;
        step();
        @(negedge clk);
        dcheck("b2b_drained", 32'(out_valid), 32'd0);
        step();

        // Flush beats a simultaneous load
        out_ready = 1'b0;
        drive(32'h300, 5'd1, 32'd11, 5'd2, 32'd22, 32'h0, 4'b0000, 1'b0, 1'b0, 5'd7, 1'b1);
        step();
        drive(32'h304, 5'd1, 32'd33, 5'd2, 32'd44, 32'h0, 4'b0000, 1'b0, 1'b0, 5'd8, 1'b1);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        dcheck("flush_valid", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        dcheck("flush_discard", 32'(out_valid), 32'd0);
        step();

        // Operand select: LUI then AUIPC
        drive(32'h400, 5'd0, 32'd0, 5'd5, 32'hDEAD, 32'h12345000, 4'b1001, 1'b0, 1'b1, 5'd8, 1'b1);
        push_exp(32'd0, 32'h12345000, 4'b1001, 32'hDEAD, 5'd8, 1'b1);
        step();
        drive(32'h100, 5'd9, 32'h77, 5'd0, 32'd0, 32'h2000, 4'b0000, 1'b1, 1'b1, 5'd9, 1'b1);
        push_exp(32'h100, 32'h2000, 4'b0000, 32'd0, 5'd9, 1'b1);
        step();
        in_valid = 1'b0;

        for (int n = 0; n < 20 && sb_q.size() > 0; n++) step();
        dcheck("sb_drained", 32'(sb_q.size()), 32'd0);
        step();
        done = 1'b1;
    end

endmodule
